video_ddr_arbiter: RTL and testbench
====================================

VIDEO_DDR_ARBITER -- requirements
Module: video_ddr_arbiter

Interface
REQ-001 Parameter AXI_ADDR_WIDTH, default 32: width of the request and command address.
REQ-002 Parameter AXI_DATA_WIDTH, default 128: AXI data width, used only to set address alignment.
REQ-003 Parameter TIMEOUT_CYCLES, default 4096: maximum number of BUSY cycles before the watchdog aborts a transaction.
REQ-004 Clock and reset (already decided): one clock; reset is asynchronous and active-high. Ports: i_clk  in  1  clock; i_reset  in  1  asynchronous active-high reset.
REQ-005 i_ddr_init_done  in  1  DDR calibration done; asynchronous to i_clk.
REQ-006 i_wr_req  in  1  write-side burst request; level, held until o_wr_gnt.
REQ-007 i_wr_addr  in  AXI_ADDR_WIDTH  write burst start address.
REQ-008 i_wr_burst_len  in  8  write AXI length (beats-1).
REQ-009 i_wr_frame_reset  in  1  write-side frame reset.
REQ-010 i_rd_req, i_rd_addr, i_rd_burst_len, i_rd_frame_reset  in  1/AXI_ADDR_WIDTH/8/1  read-side equivalents of REQ-006 to REQ-009.
REQ-011 o_wr_gnt, o_rd_gnt  out  1  one-cycle grant pulses.
REQ-012 o_cmd_vld  out  1  command valid to the AXI master engine.
REQ-013 o_cmd_rnw  out  1  1 = read command, 0 = write command.
REQ-014 o_cmd_addr  out  AXI_ADDR_WIDTH  aligned command address.
REQ-015 o_cmd_len  out  8  AXI length of the command.
REQ-016 i_cmd_rdy  in  1  engine accepts the command.
REQ-017 i_cmd_done  in  1  one-cycle pulse marking transaction completion (BRESP for writes, RLAST for reads).
REQ-018 o_timeout  out  1  one-cycle watchdog expiry pulse.
REQ-019 o_busy  out  1  high when the FSM state is not IDLE.

Function
REQ-020 i_ddr_init_done shall pass through a 2-FF synchronizer; no request shall be granted while the synchronized value is 0.
REQ-021 The FSM shall have three states: IDLE, ISSUE and BUSY, with at most one transaction outstanding.
REQ-022 IDLE -> ISSUE on the first cycle any eligible request is present.
REQ-023 A requester is eligible when its req is high and its frame_reset is low.
REQ-024 The winner shall be registered at the IDLE -> ISSUE transition.
REQ-025 Arbitration shall be round-robin: when both sides are eligible, the side not granted last wins; after reset, write has priority.
REQ-026 In ISSUE, o_cmd_vld=1 and o_cmd_rnw/addr/len shall stay stable until the cycle i_cmd_rdy=1; that handshake moves the FSM to BUSY.
REQ-027 o_cmd_addr shall equal the requester address with its low log2(AXI_DATA_WIDTH/8) bits forced to 0.
REQ-028 o_cmd_len shall pass through the requester burst length unmodified; 0 is legal and means 1 beat.
REQ-029 The matching grant pulse shall assert the cycle after the handshake; the last-granted side shall update at the same time.
REQ-030 In BUSY, i_cmd_done shall return the FSM to IDLE on the next cycle; i_cmd_done outside BUSY shall be ignored.
REQ-031 A new arbitration may start in the IDLE cycle immediately following BUSY, giving a minimum of 3 cycles per transaction.
REQ-032 In BUSY, a 16-bit-or-wider watchdog counts from 0. When it reaches TIMEOUT_CYCLES-1 without i_cmd_done, o_timeout shall pulse and the FSM shall return to IDLE.
REQ-033 The watchdog shall clear on every BUSY entry.
REQ-034 If the granted side's frame_reset asserts in ISSUE before the handshake: drop o_cmd_vld next cycle, return to IDLE, issue no grant, leave the last-granted side unchanged.
REQ-035 A frame_reset asserted in BUSY shall not abort the transaction.
REQ-036 If i_cmd_rdy and the granted frame_reset are both high in the same ISSUE cycle, the handshake shall win.
REQ-037 If the synchronized init_done drops, no new grants shall be issued; an in-flight transaction shall complete normally.

Reset
REQ-038 Asserting i_reset shall immediately force: FSM = IDLE, all outputs = 0, last-granted side = read (so write wins first), watchdog = 0, synchronizer = 0.
REQ-039 Release of i_reset shall be synchronized internally to i_clk; reset mid-transaction shall abandon the transaction without any grant or timeout pulse.

Verification
REQ-040 init_done=1, wr_req with addr 0x0000_100F, len 0x3F, rdy tied 1 -> o_cmd_addr 0x0000_1000, len 0x3F, rnw 0; o_wr_gnt one cycle after the handshake.
REQ-041 wr_req and rd_req held continuously, done returned 2 cycles after each handshake -> grants alternate W,R,W,R with write first.
REQ-042 i_cmd_done withheld, TIMEOUT_CYCLES=16 -> o_timeout pulses after 16 BUSY cycles, FSM in IDLE the next cycle, no stuck o_busy.
REQ-043 rd_frame_reset pulsed during ISSUE with rdy=0 -> o_cmd_vld drops, no o_rd_gnt, and a pending write is granted next.
REQ-044 i_reset asserted in BUSY -> o_busy and o_cmd_vld are 0 immediately; the first post-reset grant goes to write.
REQ-045 init_done=0 with both reqs high -> no o_cmd_vld; after init_done rises, the first o_cmd_vld appears no earlier than 3 cycles later.

Source files
------------

// File: rtl/video_ddr_arbiter.sv
// video_ddr_arbiter
//   Round-robin arbiter between a video write path and a video read path that
//   share one AXI master engine. Only one transaction is outstanding at a time.
//   A watchdog aborts a transaction whose completion never arrives.
//
// Ports
//   i_clk, i_reset                 clock, asynchronous active-high reset
//   i_ddr_init_done                DDR calibration done (asynchronous, synchronized here)
//   i_wr_req/addr/burst_len        write-side burst request (level, held until grant)
//   i_wr_frame_reset               write-side frame reset (makes the side ineligible)
//   i_rd_*                         read-side equivalents
//   o_wr_gnt, o_rd_gnt             one-cycle grant pulses, the cycle after the handshake
//   o_cmd_vld/rnw/addr/len         command to the AXI engine, accepted with i_cmd_rdy
//   i_cmd_done                     one-cycle completion pulse from the engine
//   o_timeout                      one-cycle watchdog expiry pulse
//   o_busy                         FSM is not idle
module video_ddr_arbiter #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 128,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_ddr_init_done,
  input  logic                      i_wr_req,
  input  logic [AXI_ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [7:0]                i_wr_burst_len,
  input  logic                      i_wr_frame_reset,
  input  logic                      i_rd_req,
  input  logic [AXI_ADDR_WIDTH-1:0] i_rd_addr,
  input  logic [7:0]                i_rd_burst_len,
  input  logic                      i_rd_frame_reset,
  output logic                      o_wr_gnt,
  output logic                      o_rd_gnt,
  output logic                      o_cmd_vld,
  output logic                      o_cmd_rnw,
  output logic [AXI_ADDR_WIDTH-1:0] o_cmd_addr,
  output logic [7:0]                o_cmd_len,
  input  logic                      i_cmd_rdy,
  input  logic                      i_cmd_done,
  output logic                      o_timeout,
  output logic                      o_busy
);

  localparam int ALIGN_BITS = $clog2(AXI_DATA_WIDTH / 8);
  localparam int WD_W       = ($clog2(TIMEOUT_CYCLES) > 16) ? $clog2(TIMEOUT_CYCLES) : 16;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_BUSY  = 2'd2
  } state_t;

  // Clear the low address bits so every command starts on a data-bus boundary.
  function automatic logic [AXI_ADDR_WIDTH-1:0] f_align(input logic [AXI_ADDR_WIDTH-1:0] addr);
    logic [AXI_ADDR_WIDTH-1:0] mask;
    mask = '1;
    mask = mask << ALIGN_BITS;
    return addr & mask;
  endfunction

  logic [1:0]                r_rst_sync;
  logic                      w_rst;
  logic [1:0]                r_init_sync;
  logic                      w_init_ok;
  logic                      w_wr_elig;
  logic                      w_rd_elig;
  logic                      w_pick_rd;
  logic                      w_gnt_frame_reset;

  state_t                    r_state;
  logic                      r_last_rd;
  logic [WD_W-1:0]           r_wdog;
  logic                      r_cmd_vld;
  logic                      r_cmd_rnw;
  logic [AXI_ADDR_WIDTH-1:0] r_cmd_addr;
  logic [7:0]                r_cmd_len;
  logic                      r_wr_gnt;
  logic                      r_rd_gnt;
  logic                      r_timeout;
  logic                      r_busy;

  // Reset asserts asynchronously but releases only after two clock edges,
  // so no flop sees a reset release close to the clock edge.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_rst_sync <= 2'b11;
    else         r_rst_sync <= {r_rst_sync[0], 1'b0};
  end
  assign w_rst = r_rst_sync[1];

  always_ff @(posedge i_clk or posedge w_rst) begin
    if (w_rst) r_init_sync <= 2'b00;
    else       r_init_sync <= {r_init_sync[0], i_ddr_init_done};
  end
  assign w_init_ok = r_init_sync[1];

  assign w_wr_elig = i_wr_req & ~i_wr_frame_reset;
  assign w_rd_elig = i_rd_req & ~i_rd_frame_reset;
  // With both sides eligible the side not granted last wins.
  assign w_pick_rd = (w_wr_elig & w_rd_elig) ? ~r_last_rd : w_rd_elig;
  assign w_gnt_frame_reset = r_cmd_rnw ? i_rd_frame_reset : i_wr_frame_reset;

  always_ff @(posedge i_clk or posedge w_rst) begin
    if (w_rst) begin
      r_state    <= S_IDLE;
      r_last_rd  <= 1'b1;
      r_wdog     <= '0;
      r_cmd_vld  <= 1'b0;
      r_cmd_rnw  <= 1'b0;
      r_cmd_addr <= '0;
      r_cmd_len  <= '0;
      r_wr_gnt   <= 1'b0;
      r_rd_gnt   <= 1'b0;
      r_timeout  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_wr_gnt  <= 1'b0;
      r_rd_gnt  <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_init_ok && (w_wr_elig || w_rd_elig)) begin
            r_state    <= S_ISSUE;
            r_busy     <= 1'b1;
            r_cmd_vld  <= 1'b1;
            r_cmd_rnw  <= w_pick_rd;
            r_cmd_addr <= f_align(w_pick_rd ? i_rd_addr : i_wr_addr);
            r_cmd_len  <= w_pick_rd ? i_rd_burst_len : i_wr_burst_len;
          end
        end
        S_ISSUE: begin
          // The handshake takes precedence over a simultaneous frame reset.
          if (i_cmd_rdy) begin
            r_state   <= S_BUSY;
            r_cmd_vld <= 1'b0;
            r_wdog    <= '0;
            r_wr_gnt  <= ~r_cmd_rnw;
            r_rd_gnt  <= r_cmd_rnw;
            r_last_rd <= r_cmd_rnw;
          end else if (w_gnt_frame_reset) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_cmd_vld <= 1'b0;
          end
        end
        S_BUSY: begin
          if (i_cmd_done) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (r_wdog == WD_LAST) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_timeout <= 1'b1;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_busy    <= 1'b0;
          r_cmd_vld <= 1'b0;
        end
      endcase
    end
  end

  assign o_wr_gnt   = r_wr_gnt;
  assign o_rd_gnt   = r_rd_gnt;
  assign o_cmd_vld  = r_cmd_vld;
  assign o_cmd_rnw  = r_cmd_rnw;
  assign o_cmd_addr = r_cmd_addr;
  assign o_cmd_len  = r_cmd_len;
  assign o_timeout  = r_timeout;
  assign o_busy     = r_busy;

endmodule

// File: tb/tb_video_ddr_arbiter.sv
// tb_video_ddr_arbiter
//   Directed testbench for video_ddr_arbiter with hand-computed expectations.
//   Watchdog shortened to 16 cycles. Inputs change and outputs are sampled
//   1 ns after the rising clock edge.
module tb_video_ddr_arbiter;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          i_reset;
  logic          i_ddr_init_done;
  logic          i_wr_req;
  logic [AW-1:0] i_wr_addr;
  logic [7:0]    i_wr_burst_len;
  logic          i_wr_frame_reset;
  logic          i_rd_req;
  logic [AW-1:0] i_rd_addr;
  logic [7:0]    i_rd_burst_len;
  logic          i_rd_frame_reset;
  logic          o_wr_gnt;
  logic          o_rd_gnt;
  logic          o_cmd_vld;
  logic          o_cmd_rnw;
  logic [AW-1:0] o_cmd_addr;
  logic [7:0]    o_cmd_len;
  logic          i_cmd_rdy;
  logic          i_cmd_done;
  logic          o_timeout;
  logic          o_busy;

  int n_vec = 0;
  int n_err = 0;

  video_ddr_arbiter #(
    .AXI_ADDR_WIDTH (AW),
    .AXI_DATA_WIDTH (128),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .i_clk            (clk),
    .i_reset          (i_reset),
    .i_ddr_init_done  (i_ddr_init_done),
    .i_wr_req         (i_wr_req),
    .i_wr_addr        (i_wr_addr),
    .i_wr_burst_len   (i_wr_burst_len),
    .i_wr_frame_reset (i_wr_frame_reset),
    .i_rd_req         (i_rd_req),
    .i_rd_addr        (i_rd_addr),
    .i_rd_burst_len   (i_rd_burst_len),
    .i_rd_frame_reset (i_rd_frame_reset),
    .o_wr_gnt         (o_wr_gnt),
    .o_rd_gnt         (o_rd_gnt),
    .o_cmd_vld        (o_cmd_vld),
    .o_cmd_rnw        (o_cmd_rnw),
    .o_cmd_addr       (o_cmd_addr),
    .o_cmd_len        (o_cmd_len),
    .i_cmd_rdy        (i_cmd_rdy),
    .i_cmd_done       (i_cmd_done),
    .o_timeout        (o_timeout),
    .o_busy           (o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance until a grant pulse is visible, bounded.
  task automatic wait_gnt(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (o_wr_gnt || o_rd_gnt) break;
      step();
    end
    chk(tag, 64'(o_wr_gnt | o_rd_gnt), 64'd1);
  endtask

  // Called in the grant cycle: completion arrives two cycles after the handshake.
  task automatic finish_txn();
    step();
    i_cmd_done = 1'b1;
    step();
    i_cmd_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: got expired, expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    i_reset          = 1'b1;
    i_ddr_init_done  = 1'b0;
    i_wr_req         = 1'b0;
    i_wr_addr        = '0;
    i_wr_burst_len   = '0;
    i_wr_frame_reset = 1'b0;
    i_rd_req         = 1'b0;
    i_rd_addr        = '0;
    i_rd_burst_len   = '0;
    i_rd_frame_reset = 1'b0;
    i_cmd_rdy        = 1'b0;
    i_cmd_done       = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_vld",   64'(o_cmd_vld), 64'd0);
    chk("rst_busy",  64'(o_busy), 64'd0);
    chk("rst_gnt",   64'({o_wr_gnt, o_rd_gnt}), 64'd0);
    chk("rst_tmo",   64'(o_timeout), 64'd0);
    chk("rst_addr",  64'(o_cmd_addr), 64'd0);
    i_reset         = 1'b0;
    i_ddr_init_done = 1'b1;
    for (int i = 0; i < 5; i++) step();

    // Single aligned write, rdy tied high
    i_cmd_rdy      = 1'b1;
    i_wr_req       = 1'b1;
    i_wr_addr      = 32'h0000_100F;
    i_wr_burst_len = 8'h3F;
    step();
    chk("t1_vld",  64'(o_cmd_vld), 64'd1);
    chk("t1_addr", 64'(o_cmd_addr), 64'h1000);
    chk("t1_len",  64'(o_cmd_len), 64'h3F);
    chk("t1_rnw",  64'(o_cmd_rnw), 64'd0);
    chk("t1_nogn", 64'(o_wr_gnt), 64'd0);
    step();
    chk("t1_gnt",  64'({o_wr_gnt, o_rd_gnt}), 64'd2);
    chk("t1_vld0", 64'(o_cmd_vld), 64'd0);
    chk("t1_busy", 64'(o_busy), 64'd1);
    i_wr_req = 1'b0;
    step();
    chk("t1_gnt1cyc", 64'(o_wr_gnt), 64'd0);
    i_cmd_done = 1'b1;
    step();
    i_cmd_done = 1'b0;
    chk("t1_idle", 64'(o_busy), 64'd0);

    // Watchdog: done withheld, expiry after 16 BUSY cycles
    i_wr_req       = 1'b1;
    i_wr_addr      = 32'h0000_0040;
    i_wr_burst_len = 8'h07;
    wait_gnt("t2_gnt_seen");
    chk("t2_wgnt", 64'(o_wr_gnt), 64'd1);
    i_wr_req = 1'b0;
    for (int i = 0; i < 15; i++) step();
    chk("t2_tmo_early", 64'(o_timeout), 64'd0);
    chk("t2_busy16",    64'(o_busy), 64'd1);
    step();
    chk("t2_tmo",       64'(o_timeout), 64'd1);
    chk("t2_idle",      64'(o_busy), 64'd0);
    step();
    chk("t2_tmo_pulse", 64'(o_timeout), 64'd0);
    chk("t2_idle2",     64'(o_busy), 64'd0);

    // Frame reset during ISSUE: last grant was write, so read wins this round
    i_cmd_rdy      = 1'b0;
    i_wr_req       = 1'b1;
    i_wr_addr      = 32'h0000_8008;
    i_wr_burst_len = 8'h10;
    i_rd_req       = 1'b1;
    i_rd_addr      = 32'h0000_2345;
    i_rd_burst_len = 8'h00;
    step();
    chk("t3_vld",  64'(o_cmd_vld), 64'd1);
    chk("t3_rnw",  64'(o_cmd_rnw), 64'd1);
    chk("t3_addr", 64'(o_cmd_addr), 64'h2340);
    chk("t3_len0", 64'(o_cmd_len), 64'd0);
    i_cmd_done = 1'b1;
    step();
    i_cmd_done = 1'b0;
    chk("t3_done_ignored", 64'(o_cmd_vld), 64'd1);
    chk("t3_stable_addr",  64'(o_cmd_addr), 64'h2340);
    i_rd_frame_reset = 1'b1;
    step();
    chk("t3_vld_drop", 64'(o_cmd_vld), 64'd0);
    chk("t3_abort",    64'(o_busy), 64'd0);
    chk("t3_no_rgnt",  64'(o_rd_gnt), 64'd0);
    i_cmd_rdy = 1'b1;
    step();
    chk("t3_w_vld",  64'(o_cmd_vld), 64'd1);
    chk("t3_w_rnw",  64'(o_cmd_rnw), 64'd0);
    chk("t3_w_addr", 64'(o_cmd_addr), 64'h8000);
    step();
    chk("t3_w_gnt", 64'({o_wr_gnt, o_rd_gnt}), 64'd2);
    i_wr_req         = 1'b0;
    i_rd_req         = 1'b0;
    i_rd_frame_reset = 1'b0;
    finish_txn();
    chk("t3_idle", 64'(o_busy), 64'd0);

    // Handshake beats a simultaneous frame reset; frame reset in BUSY is harmless
    i_cmd_rdy      = 1'b0;
    i_wr_req       = 1'b1;
    i_wr_addr      = 32'h0000_0123;
    i_wr_burst_len = 8'h01;
    step();
    chk("t4_vld", 64'(o_cmd_vld), 64'd1);
    i_cmd_rdy        = 1'b1;
    i_wr_frame_reset = 1'b1;
    step();
    chk("t4_gnt",  64'(o_wr_gnt), 64'd1);
    chk("t4_busy", 64'(o_busy), 64'd1);
    i_wr_req = 1'b0;
    step();
    chk("t4_busy_fr", 64'(o_busy), 64'd1);
    i_wr_frame_reset = 1'b0;
    i_cmd_done       = 1'b1;
    step();
    i_cmd_done = 1'b0;
    chk("t4_idle", 64'(o_busy), 64'd0);

    // init_done drops mid-transaction: it completes, then nothing more is issued
    i_wr_req       = 1'b1;
    i_wr_addr      = 32'h0000_0200;
    i_wr_burst_len = 8'h02;
    wait_gnt("t5_gnt_seen");
    chk("t5_wgnt", 64'(o_wr_gnt), 64'd1);
    i_ddr_init_done = 1'b0;
    i_rd_req        = 1'b1;
    i_rd_addr       = 32'h0000_0310;
    i_rd_burst_len  = 8'h04;
    step();
    step();
    step();
    chk("t5_inflight", 64'(o_busy), 64'd1);
    i_cmd_done = 1'b1;
    step();
    i_cmd_done = 1'b0;
    chk("t5_done", 64'(o_busy), 64'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("t5_hold%0d", i), 64'(o_cmd_vld), 64'd0);
    end
    i_ddr_init_done = 1'b1;
    step();
    chk("t5_sync1", 64'(o_cmd_vld), 64'd0);
    step();
    chk("t5_sync2", 64'(o_cmd_vld), 64'd0);
    for (int i = 0; i < 5; i++) begin
      if (o_cmd_vld) break;
      step();
    end
    chk("t5_vld_after_init", 64'(o_cmd_vld), 64'd1);
    chk("t5_rr_read",        64'(o_cmd_rnw), 64'd1);
    chk("t5_rd_addr",        64'(o_cmd_addr), 64'h0310);

    // Reset while BUSY, then write must win first and grants alternate
    wait_gnt("t6_gnt_seen");
    chk("t6_rgnt", 64'(o_rd_gnt), 64'd1);
    i_reset = 1'b1;
    #1;
    chk("t6_busy_now", 64'(o_busy), 64'd0);
    chk("t6_vld_now",  64'(o_cmd_vld), 64'd0);
    chk("t6_gnt_now",  64'({o_wr_gnt, o_rd_gnt}), 64'd0);
    step();
    step();
    i_reset = 1'b0;
    step();
    chk("t6_no_tmo", 64'(o_timeout), 64'd0);
    chk("t6_no_gnt", 64'({o_wr_gnt, o_rd_gnt}), 64'd0);
    for (int k = 0; k < 4; k++) begin
      wait_gnt($sformatf("alt%0d_seen", k));
      chk($sformatf("alt%0d", k), 64'({o_wr_gnt, o_rd_gnt}), (k % 2 == 0) ? 64'd2 : 64'd1);
      finish_txn();
    end
    i_wr_req = 1'b0;
    i_rd_req = 1'b0;
    step();
    chk("end_idle", 64'(o_busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
